prefetch_queue: RTL and testbench



---
 rtl/prefetch_pkg.sv | 30 +++
 rtl/multi_write_fifo.sv | 63 ++++++
 rtl/prefetch_queue.sv | 123 ++++++++++++
 tb/tb_prefetch_queue.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the instruction prefetcher.
package prefetch_pkg;

   localparam logic [15:0] DEFAULT_RESET_CS = 16'hFFFF;
   localparam logic [15:0] DEFAULT_RESET_IP = 16'h0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DISCARD
   } fetch_state_t;

   // 20-bit real-mode physical address; the carry out of bit 19 is dropped.
   function automatic logic [19:0] phys_addr(input logic [15:0] cs, input logic [15:0] ip);
      return {cs, 4'b0000} + {4'b0000, ip};
   endfunction

   // Bytes usable from one bus beat: stop at the end of the beat or at the
   // IP wrap point, whichever comes first.
   function automatic logic [2:0] fetch_count(input logic [1:0] offset,
                                              input logic [15:0] ip,
                                              input int bus_bytes);
      int to_bus_end;
      int to_wrap;
      to_bus_end = bus_bytes - int'(offset);
      to_wrap    = 32'h0001_0000 - int'(ip);
      return (to_bus_end < to_wrap) ? 3'(to_bus_end) : 3'(to_wrap);
   endfunction

endpackage

// File: rtl/multi_write_fifo.sv
// Byte FIFO that accepts up to WR_BYTES bytes per cycle and pops one byte.
module multi_write_fifo #(
   parameter int DEPTH    = 6,
   parameter int WR_BYTES = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         wr_en,
   input  logic [2:0]                   wr_count,
   input  logic [WR_BYTES*8-1:0]        wr_data,
   input  logic                         rd_en,
   output logic [7:0]                   rd_data,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH+1);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] count_q;
   logic          do_rd;

   // Circular pointer advance for a depth that need not be a power of two.
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return PW'(s);
   endfunction

   assign empty   = (count_q == '0);
   assign level   = count_q;
   assign do_rd   = rd_en && !empty;
   assign rd_data = empty ? 8'h00 : mem[rd_ptr];

   // Pointers and occupancy; a flush empties the queue and beats read/write.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_add(wr_ptr, int'(wr_count));
         if (do_rd) rd_ptr <= ptr_add(rd_ptr, 1);
         count_q <= count_q + (wr_en ? LW'(wr_count) : LW'(0)) - LW'(do_rd);
      end
   end

   // Byte storage: all bytes of one beat land in the same cycle.
   // NOTE: storage has no reset; empty gates rd_data so stale bytes never show.
   always_ff @(posedge clk) begin
      if (wr_en && !flush && !reset) begin
         for (int i = 0; i < WR_BYTES; i++) begin
            if (i < int'(wr_count)) mem[ptr_add(wr_ptr, i)] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetcher: fetch sequencing from CS:IP, byte queue, head-IP tracking.
module prefetch_queue
   import prefetch_pkg::*;
#(
   parameter int          DEPTH     = 6,
   parameter int          BUS_BYTES = 2,
   parameter logic [15:0] RESET_CS  = DEFAULT_RESET_CS,
   parameter logic [15:0] RESET_IP  = DEFAULT_RESET_IP
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               load_new_ip,
   input  logic [15:0]                        new_cs,
   input  logic [15:0]                        new_ip,
   input  logic                               rd_en,
   output logic [7:0]                         rd_data,
   output logic                               empty,
   output logic [$clog2(DEPTH+1)-1:0]         level,
   output logic [15:0]                        head_ip,
   output logic                               mem_access,
   input  logic                               mem_ack,
   output logic [19-$clog2(BUS_BYTES):0]      mem_address,
   input  logic [BUS_BYTES*8-1:0]             mem_data
);

   localparam int AW = $clog2(BUS_BYTES);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [LW-1:0] ROOM_LIMIT = LW'(DEPTH - BUS_BYTES);

   fetch_state_t           state;
   logic [15:0]            cs;
   logic [15:0]            fetch_ip;
   logic [19:0]            cur_phys;
   logic [19:0]            issue_phys;
   logic [1:0]             offset;
   logic [2:0]             count;
   logic [BUS_BYTES*8-1:0] aligned_data;
   logic                   accept_ack;
   logic                   pop;
   logic                   room_ok;

   // Address, byte count and control decode for the current cycle.
   // NOTE: every always_comb output gets a value up front, so no latch can form.
   always_comb begin
      cur_phys     = phys_addr(cs, fetch_ip);
      issue_phys   = load_new_ip ? phys_addr(new_cs, new_ip) : cur_phys;
      offset       = cur_phys[1:0] & 2'(BUS_BYTES - 1);
      count        = fetch_count(offset, fetch_ip, BUS_BYTES);
      aligned_data = mem_data >> {offset, 3'b000};
      accept_ack   = (state == S_FETCH) && mem_ack && !load_new_ip;
      pop          = rd_en && !empty && !load_new_ip;
      // A redirect flushes the queue, so there is always room for its fetch.
      room_ok      = load_new_ip || (level <= ROOM_LIMIT);
   end

   multi_write_fifo #(
      .DEPTH    (DEPTH),
      .WR_BYTES (BUS_BYTES)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (load_new_ip),
      .wr_en    (accept_ack),
      .wr_count (count),
      .wr_data  (aligned_data),
      .rd_en    (pop),
      .rd_data  (rd_data),
      .empty    (empty),
      .level    (level)
   );

   // Fetch FSM with registered bus request; S_DISCARD swallows the ack of a
   // request that a redirect made stale, since the bus cannot abort it.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         mem_access  <= 1'b0;
         mem_address <= '0;
         cs          <= RESET_CS;
         fetch_ip    <= RESET_IP;
         head_ip     <= RESET_IP;
      end else begin
         if (load_new_ip) begin
            cs       <= new_cs;
            fetch_ip <= new_ip;
            head_ip  <= new_ip;
         end else begin
            if (pop)        head_ip  <= head_ip + 16'd1;
            if (accept_ack) fetch_ip <= fetch_ip + 16'(count);
         end

         case (state)
            S_IDLE: begin
               if (room_ok) begin
                  state       <= S_FETCH;
                  mem_access  <= 1'b1;
                  mem_address <= issue_phys[19:AW];
               end
            end
            S_FETCH: begin
               if (mem_ack) begin
                  state      <= S_IDLE;
                  mem_access <= 1'b0;
               end else if (load_new_ip) begin
                  state <= S_DISCARD;
               end
            end
            S_DISCARD: begin
               if (mem_ack) begin
                  state      <= S_IDLE;
                  mem_access <= 1'b0;
               end
            end
            default: begin
               state      <= S_IDLE;
               mem_access <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue (DEPTH=6, BUS_BYTES=2).
module tb_prefetch_queue;
   import prefetch_pkg::*;

   localparam int DEPTH     = 6;
   localparam int BUS_BYTES = 2;
   localparam int LW        = $clog2(DEPTH+1);
   localparam int MAW       = 20 - $clog2(BUS_BYTES);

   typedef struct packed {
      logic [7:0]  data;
      logic [15:0] ip;
   } rd_exp_t;

   logic                   clk;
   logic                   reset;
   logic                   load_new_ip;
   logic [15:0]            new_cs;
   logic [15:0]            new_ip;
   logic                   rd_en;
   logic [7:0]             rd_data;
   logic                   empty;
   logic [LW-1:0]          level;
   logic [15:0]            head_ip;
   logic                   mem_access;
   logic                   mem_ack;
   logic [MAW-1:0]         mem_address;
   logic [BUS_BYTES*8-1:0] mem_data;

   int checks = 0;
   int errors = 0;

   logic [MAW-1:0] exp_addr [$];
   rd_exp_t        exp_rd   [$];
   bit             req_logged = 1'b0;

   prefetch_queue #(
      .DEPTH     (DEPTH),
      .BUS_BYTES (BUS_BYTES),
      .RESET_CS  (16'hFFFF),
      .RESET_IP  (16'h0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load_new_ip (load_new_ip),
      .new_cs      (new_cs),
      .new_ip      (new_ip),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .level       (level),
      .head_ip     (head_ip),
      .mem_access  (mem_access),
      .mem_ack     (mem_ack),
      .mem_address (mem_address),
      .mem_data    (mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare each new bus request and each accepted pop with the scoreboard.
   always @(negedge clk) begin
      logic [MAW-1:0] ea;
      rd_exp_t        er;
      if (mem_access === 1'b1 && !req_logged) begin
         checks++;
         if (exp_addr.size() == 0) begin
            errors++;
            $display("FAIL fetch_unexpected: got addr %h expected no request", mem_address);
         end else begin
            ea = exp_addr.pop_front();
            if (mem_address !== ea) begin
               errors++;
               $display("FAIL fetch_addr: got %h expected %h", mem_address, ea);
            end
         end
      end
      req_logged = (mem_access === 1'b1);

      if (rd_en === 1'b1 && empty === 1'b0 && load_new_ip === 1'b0 && reset === 1'b0) begin
         checks++;
         if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got byte %h ip %h expected no pop", rd_data, head_ip);
         end else begin
            er = exp_rd.pop_front();
            if (rd_data !== er.data || head_ip !== er.ip) begin
               errors++;
               $display("FAIL pop_data: got byte %h ip %h expected byte %h ip %h",
                        rd_data, head_ip, er.data, er.ip);
            end
         end
      end
   end

   // Acknowledge the outstanding request, waiting a bounded time for it.
   task automatic ack(input logic [15:0] d);
      int n = 0;
      while (mem_access !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (mem_access !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got mem_access %b expected 1", mem_access);
      end
      mem_ack  = 1'b1;
      mem_data = d;
      step();
      mem_ack  = 1'b0;
      mem_data = '0;
   endtask

   // Reset, check reset state, then release with a stray ack that must be ignored.
   task automatic do_reset();
      reset = 1'b1; load_new_ip = 1'b0; rd_en = 1'b0; mem_ack = 1'b0;
      step();
      check("reset_access", {31'd0, mem_access}, 32'd0);
      check("reset_empty", {31'd0, empty}, 32'd1);
      check("reset_level", 32'(level), 32'd0);
      check("reset_rd_data", {24'd0, rd_data}, 32'd0);
      check("reset_head_ip", {16'd0, head_ip}, 32'h0000);
      step();
      exp_addr.push_back(19'h7FFF8);
      reset    = 1'b0;
      mem_ack  = 1'b1;
      mem_data = '1;
      step();
      mem_ack  = 1'b0;
      mem_data = '0;
      check("stray_ack_level", 32'(level), 32'd0);
      check("first_fetch", {31'd0, mem_access}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; load_new_ip = 1'b0; new_cs = '0; new_ip = '0;
      rd_en = 1'b0; mem_ack = 1'b0; mem_data = '0;

      // Reset and first fetch from FFFF:0000.
      do_reset();
      ack(16'h1234);
      check("ack_empty", {31'd0, empty}, 32'd0);
      check("ack_level", 32'(level), 32'd2);
      check("ack_head", {24'd0, rd_data}, 32'h34);
      exp_addr.push_back(19'h7FFF9);
      exp_rd.push_back('{data: 8'h34, ip: 16'h0000});
      exp_rd.push_back('{data: 8'h12, ip: 16'h0001});
      rd_en = 1'b1;
      step();
      step();
      rd_en = 1'b0;
      check("drain_empty", {31'd0, empty}, 32'd1);
      check("drain_head_ip", {16'd0, head_ip}, 32'h0002);

      // Fill from empty: three fetches reach level 6, then the bus stays idle.
      ack(16'h5678);
      exp_addr.push_back(19'h7FFFA);
      ack(16'h9ABC);
      exp_addr.push_back(19'h7FFFB);
      ack(16'hDEF0);
      repeat (3) step();
      check("full_level", 32'(level), 32'd6);
      check("full_no_fetch", {31'd0, mem_access}, 32'd0);
      exp_rd.push_back('{data: 8'h78, ip: 16'h0002});
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("one_read_level", 32'(level), 32'd5);
      step();
      step();
      check("one_read_no_fetch", {31'd0, mem_access}, 32'd0);
      exp_rd.push_back('{data: 8'h56, ip: 16'h0003});
      exp_addr.push_back(19'h7FFFC);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      step();
      check("two_reads_fetch", {31'd0, mem_access}, 32'd1);

      // Simultaneous pop and 2-byte ack at level 4.
      exp_rd.push_back('{data: 8'hBC, ip: 16'h0004});
      rd_en = 1'b1;
      ack(16'h1357);
      rd_en = 1'b0;
      check("rd_ack_level", 32'(level), 32'd5);

      // Drain completely, then read while empty.
      exp_addr.push_back(19'h7FFFD);
      exp_rd.push_back('{data: 8'h9A, ip: 16'h0005});
      exp_rd.push_back('{data: 8'hF0, ip: 16'h0006});
      exp_rd.push_back('{data: 8'hDE, ip: 16'h0007});
      exp_rd.push_back('{data: 8'h57, ip: 16'h0008});
      exp_rd.push_back('{data: 8'h13, ip: 16'h0009});
      rd_en = 1'b1;
      repeat (5) step();
      step();
      step();
      rd_en = 1'b0;
      check("rd_empty_level", 32'(level), 32'd0);
      check("rd_empty_head_ip", {16'd0, head_ip}, 32'h000A);
      check("rd_empty_empty", {31'd0, empty}, 32'd1);

      // Redirect while the fetch at 7FFFD is outstanding.
      load_new_ip = 1'b1; new_cs = 16'h0000; new_ip = 16'h2000;
      step();
      load_new_ip = 1'b0;
      check("discard_hold_access", {31'd0, mem_access}, 32'd1);
      check("discard_hold_addr", 32'(mem_address), 32'h7FFFD);
      step();
      step();
      mem_ack = 1'b1; mem_data = 16'hDEAD;
      step();
      mem_ack = 1'b0; mem_data = '0;
      check("discard_access_low", {31'd0, mem_access}, 32'd0);
      check("discard_empty", {31'd0, empty}, 32'd1);
      exp_addr.push_back(19'h01000);
      step();
      check("discard_refetch", {31'd0, mem_access}, 32'd1);
      check("discard_level", 32'(level), 32'd0);
      check("discard_head_ip", {16'd0, head_ip}, 32'h2000);

      // Redirect and ack in the same cycle, to an odd start address.
      load_new_ip = 1'b1; new_cs = 16'h0000; new_ip = 16'h0101;
      mem_ack = 1'b1; mem_data = 16'h1111;
      step();
      load_new_ip = 1'b0; mem_ack = 1'b0; mem_data = '0;
      check("redir_ack_level", 32'(level), 32'd0);
      check("redir_ack_access", {31'd0, mem_access}, 32'd0);
      check("redir_ack_head_ip", {16'd0, head_ip}, 32'h0101);
      exp_addr.push_back(19'h00080);
      ack(16'hBBAA);
      check("odd_level", 32'(level), 32'd1);
      check("odd_byte", {24'd0, rd_data}, 32'hBB);
      exp_addr.push_back(19'h00081);
      exp_rd.push_back('{data: 8'hBB, ip: 16'h0101});
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("odd_head_ip", {16'd0, head_ip}, 32'h0102);

      // Segment wrap via an idle-bus redirect from a full queue.
      do_reset();
      ack(16'h0000);
      exp_addr.push_back(19'h7FFF9);
      ack(16'h0000);
      exp_addr.push_back(19'h7FFFA);
      ack(16'h0000);
      step();
      check("wrap_full_idle", {31'd0, mem_access}, 32'd0);
      exp_addr.push_back(19'h0FFFF);
      load_new_ip = 1'b1; new_cs = 16'h1000; new_ip = 16'hFFFF;
      step();
      load_new_ip = 1'b0;
      check("idle_redirect_latency", {31'd0, mem_access}, 32'd1);
      check("idle_redirect_level", 32'(level), 32'd0);
      ack(16'h7766);
      check("wrap_level", 32'(level), 32'd1);
      check("wrap_byte", {24'd0, rd_data}, 32'h77);
      exp_addr.push_back(19'h08000);
      ack(16'h5544);
      exp_addr.push_back(19'h08001);
      check("wrap_level2", 32'(level), 32'd3);
      exp_rd.push_back('{data: 8'h77, ip: 16'hFFFF});
      exp_rd.push_back('{data: 8'h44, ip: 16'h0000});
      exp_rd.push_back('{data: 8'h55, ip: 16'h0001});
      rd_en = 1'b1;
      repeat (3) step();
      rd_en = 1'b0;
      check("wrap_head_ip", {16'd0, head_ip}, 32'h0002);
      check("wrap_empty", {31'd0, empty}, 32'd1);

      step();
      check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
      check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
